// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch address register with jump, call and return
// Optional call/return stack and RUN/FAULT state machine are built when PC_CALL_STACK_EN is defined.
module program_counter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STEP        = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  fault
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_top;
  logic                  w_ret_cmd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_pc_inc = r_pc + ADDR_WIDTH'(STEP);

  // A faulting command leaves pc, sp and stack untouched; only the state moves.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    if (r_state == RUN && enable) begin
      if (w_ret_cmd) begin
        if (w_empty) begin
          w_state_next = FAULT;
        end else begin
          w_pop     = 1'b1;
          w_pc_next = w_top;
        end
      end else if (call) begin
        if (w_full) begin
          w_state_next = FAULT;
        end else begin
          w_push    = 1'b1;
          w_pc_next = jump_target;
        end
      end else if (jump_valid) begin
        w_pc_next = jump_target;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

`ifdef PC_CALL_STACK_EN
  logic [SP_W-1:0]       r_sp;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-2:0]       w_wr_idx;
  logic [SP_W-2:0]       w_rd_idx;

  assign w_wr_idx  = r_sp[SP_W-2:0];
  assign w_rd_idx  = w_wr_idx - 1'b1;
  assign w_ret_cmd = ret;
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top     = r_stack[w_rd_idx];
  assign fault     = (r_state == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Return-address storage is plain RAM with no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_wr_idx] <= w_pc_inc;
    end
  end
`else
  logic [2:0] w_unused_cmd;

  assign w_ret_cmd    = 1'b0;
  assign w_full       = 1'b0;
  assign w_empty      = 1'b1;
  assign w_top        = '0;
  assign fault        = 1'b0;
  assign w_unused_cmd = {w_push, w_pop, ret};
`endif

  assign pc_out      = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;

  typedef struct {
    logic [7:0] pc;
    logic       full;
    logic       empty;
    logic       flt;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       jump_valid = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] pc_out;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;

  program_counter #(.ADDR_WIDTH(8), .STEP(4), .STACK_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .call        (call),
    .ret         (ret),
    .pc_out      (pc_out),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic en, input logic jv, input logic c,
                      input logic rt, input logic [7:0] tgt, input logic [7:0] epc,
                      input logic ef, input logic ee, input logic eflt, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; enable = en; jump_valid = jv; call = c; ret = rt; jump_target = tgt;
    e.pc = epc; e.full = ef; e.empty = ee; e.flt = eflt; e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({pc_out, stack_full, stack_empty, fault} !== {e.pc, e.full, e.empty, e.flt}) begin
          fails++;
          $display("FAIL %s: got pc=%02h full=%0b empty=%0b fault=%0b, want pc=%02h full=%0b empty=%0b fault=%0b",
                   e.name, pc_out, stack_full, stack_empty, fault, e.pc, e.full, e.empty, e.flt);
        end
      end
    end
  end

  initial begin : stimulus
    //    rst  en  jv  call ret  tgt    pc     full empty flt
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, "reset");
    step(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0, "idle1");
    step(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 1, 0, "idle2");
    step(0, 1, 0, 0, 0, 8'h00, 8'h0C, 0, 1, 0, "idle3");
    step(0, 0, 0, 0, 0, 8'h00, 8'h0C, 0, 1, 0, "hold1");
    step(0, 0, 1, 1, 1, 8'h77, 8'h0C, 0, 1, 0, "hold2_cmds");
    step(0, 1, 1, 0, 0, 8'hF8, 8'hF8, 0, 1, 0, "jump_f8");
    step(0, 1, 0, 0, 0, 8'h00, 8'hFC, 0, 1, 0, "inc_fc");
    step(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, "wrap");
    step(0, 1, 1, 0, 0, 8'h40, 8'h40, 0, 1, 0, "jump_40");
    step(0, 1, 1, 0, 0, 8'h10, 8'h10, 0, 1, 0, "jump_10");
`ifdef PC_CALL_STACK_EN
    step(0, 1, 0, 1, 0, 8'h80, 8'h80, 0, 0, 0, "call_80");
    step(0, 1, 0, 0, 1, 8'h00, 8'h14, 0, 1, 0, "ret_14");
    step(0, 1, 1, 0, 0, 8'h20, 8'h20, 0, 1, 0, "jump_20");
    step(0, 1, 0, 0, 1, 8'h00, 8'h20, 0, 1, 1, "ret_underflow");
    step(0, 1, 1, 0, 0, 8'h55, 8'h20, 0, 1, 1, "fault_frozen");
    step(1, 1, 1, 0, 0, 8'h55, 8'h00, 0, 1, 0, "rst_from_fault");
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 1, 0, 8'(i * 16), 8'(i * 16), (i == 8), 0, 0, $sformatf("nest_call%0d", i));
    step(0, 1, 0, 1, 0, 8'hEE, 8'h80, 1, 0, 1, "call_overflow");
    step(0, 1, 1, 0, 0, 8'h11, 8'h80, 1, 0, 1, "overflow_frozen");
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, "rst_after_overflow");
    step(0, 1, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0, "lifo_call_a");
    step(0, 1, 0, 1, 0, 8'h50, 8'h50, 0, 0, 0, "lifo_call_b");
    step(0, 1, 0, 0, 1, 8'h00, 8'h34, 0, 0, 0, "lifo_ret_b");
    step(0, 1, 0, 0, 1, 8'h00, 8'h04, 0, 1, 0, "lifo_ret_a");
    step(0, 1, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0, "call_60");
    step(0, 1, 1, 1, 1, 8'h70, 8'h08, 0, 1, 0, "ret_wins");
    step(0, 1, 1, 0, 0, 8'hFC, 8'hFC, 0, 1, 0, "jump_fc");
    step(0, 1, 0, 1, 0, 8'h90, 8'h90, 0, 0, 0, "call_at_fc");
    step(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, "ret_wrapped");
    step(1, 1, 0, 1, 0, 8'h44, 8'h00, 0, 1, 0, "rst_beats_call");
`else
    step(0, 1, 0, 1, 0, 8'h30, 8'h30, 0, 1, 0, "call_as_jump");
    step(0, 1, 0, 0, 1, 8'h00, 8'h34, 0, 1, 0, "ret_ignored");
    step(0, 1, 1, 0, 1, 8'h70, 8'h70, 0, 1, 0, "ret_jump");
    step(0, 1, 0, 1, 1, 8'hA0, 8'hA0, 0, 1, 0, "ret_call");
    step(0, 1, 0, 0, 1, 8'h00, 8'hA4, 0, 1, 0, "ret_again");
    step(1, 1, 1, 1, 0, 8'h44, 8'h00, 0, 1, 0, "rst_beats_jump");
`endif
    step(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0, "post_rst_inc");
    @(negedge clk);
    enable = 1'b0; rst = 1'b0; call = 1'b0; ret = 1'b0; jump_valid = 1'b0;
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      begin
        #100000;
        tests++;
        fails++;
        $display("FAIL timeout: stimulus did not complete, want completion within 100000 time units");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
